// File: rtl/dma_io_fifo_port.sv
// dma_io_fifo_port: producer FIFO on the shared bus that raises DMA_Req once a burst's worth of words is buffered.
// Optional burst idle timeout is built only when DMA_IO_TIMEOUT_EN is defined.
module dma_io_fifo_port #(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] BASE_ADDR  = 32'd1001,
   parameter int          REQ_THRESH = 4,
   parameter int          TIMEOUT    = 16
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic [31:0] address_Bus,
   inout  wire  [31:0] Data_Bus,
   input  logic        Read_DMA,
   input  logic        Write_DMA,
   input  logic        Read_CPU,
   input  logic        Write_CPU,
   output logic        DMA_Req,
   input  logic        DMA_Ack,
   input  logic        dev_valid,
   input  logic [31:0] dev_data,
   output logic        dev_ready
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, BURST, DRAIN} state_t;
   state_t st, st_n;
   logic [31:0] mem [DEPTH];
   logic [AW:0] wp, rp, level;
   logic [6:0] lvl, bcnt, bcnt_n;
   logic rd, wr, dhit, shit, empty, full, pop, dpop, push, flush, clr;
   logic rdy_en, ovf, und, tmo;
   logic [31:0] status;
   assign rd     = Read_DMA | Read_CPU;
   assign wr     = Write_DMA | Write_CPU;
   assign dhit   = address_Bus == BASE_ADDR;
   assign shit   = address_Bus == BASE_ADDR + 32'd1;
   assign level  = wp - rp;
   assign lvl    = 7'(level);
   assign empty  = wp == rp;
   assign full   = level == (AW+1)'(DEPTH);
   assign pop    = rd & dhit & !empty;
   assign dpop   = pop & Read_DMA;
   assign push   = dev_valid & dev_ready;
   assign flush  = wr & shit & Data_Bus[0];
   assign clr    = wr & shit & Data_Bus[1];
   assign status = {20'b0, tmo, und, ovf, 2'(st), lvl};
   assign Data_Bus  = (rd & dhit) ? (empty ? 32'h0 : mem[rp[AW-1:0]]) : (rd & shit) ? status : 'z;
   assign DMA_Req   = (st == REQ) | (st == BURST);
   assign dev_ready = rdy_en & !full;
   always_ff @(posedge CLK)
      if (push) mem[wp[AW-1:0]] <= dev_data;
   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) begin
         wp     <= '0;
         rp     <= '0;
         st     <= IDLE;
         bcnt   <= '0;
         rdy_en <= 1'b0;
         ovf    <= 1'b0;
         und    <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         st     <= st_n;
         bcnt   <= bcnt_n;
         wp     <= flush ? '0 : wp + (AW+1)'(push);
         rp     <= flush ? '0 : rp + (AW+1)'(pop);
         ovf    <= !clr & (ovf | (dev_valid & full));
         und    <= !clr & (und | (rd & dhit & empty));
      end
`ifdef DMA_IO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic tmo_set;
   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) begin
         tcnt <= '0;
         tmo  <= 1'b0;
      end else begin
         tcnt <= (st != BURST || dpop) ? '0 : tcnt + TW'(1);
         tmo  <= !clr & (tmo | tmo_set);
      end
`else
   assign tmo = 1'b0;
`endif
   // burst ends on the last counted DMA pop, or early when the FIFO runs dry
   always_comb begin
      st_n   = st;
      bcnt_n = bcnt;
`ifdef DMA_IO_TIMEOUT_EN
      tmo_set = 1'b0;
`endif
      case (st)
         IDLE:  st_n = (lvl >= 7'(REQ_THRESH)) ? REQ : IDLE;
         REQ:   if (DMA_Ack) begin
                   st_n   = BURST;
                   bcnt_n = '0;
                end
         BURST: begin
                   bcnt_n = dpop ? bcnt + 7'd1 : bcnt;
                   if (dpop && bcnt == 7'(REQ_THRESH - 1)) st_n = DRAIN;
                   else if (empty) st_n = DRAIN;
`ifdef DMA_IO_TIMEOUT_EN
                   else if (!dpop && tcnt == TW'(TIMEOUT - 1)) begin
                      st_n    = DRAIN;
                      tmo_set = 1'b1;
                   end
`endif
                end
         default: st_n = IDLE;
      endcase
      if (flush) st_n = IDLE;
   end
endmodule
